// File: rtl/mxrv_id_stage.sv
// mxrv_id_stage: RV32 instruction decode stage with a 2-entry skid buffer.
// Each accepted instruction is decoded combinationally and the full decoded
// bundle is stored, so outputs come straight from registers.
// Optional feature: define MXRV_M_EXT_EN to decode the M extension
// (OP with funct7=0000001) as legal register-register instructions.
module mxrv_id_stage #(
  parameter int XLEN = 32,
  parameter int PC_W = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush_i,
  input  logic            inst_valid_i,
  output logic            inst_ready_o,
  input  logic [31:0]     inst_data_i,
  input  logic [PC_W-1:0] inst_addr_i,
  output logic            dec_valid_o,
  input  logic            dec_ready_i,
  output logic [PC_W-1:0] dec_pc_o,
  output logic [6:0]      opcode_o,
  output logic [4:0]      rd_o,
  output logic [4:0]      rs1_o,
  output logic [4:0]      rs2_o,
  output logic [4:0]      shamt_o,
  output logic [2:0]      funct3_o,
  output logic [6:0]      funct7_o,
  output logic [XLEN-1:0] imm_o,
  output logic            rd_we_o,
  output logic            rs1_en_o,
  output logic            rs2_en_o,
  output logic            illegal_o
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [6:0]      opcode;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      shamt;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm;
    logic            rd_we;
    logic            rs1_en;
    logic            rs2_en;
    logic            illegal;
  } bundle_t;

  state_t  r_state, w_state_nx;
  logic    r_ready;
  bundle_t r_ent0, r_ent1;   // r_ent0 is always the oldest entry
  bundle_t w_dec;
  logic    w_push, w_pop;
  logic    w_is_i, w_is_s, w_is_b, w_is_u, w_is_j, w_is_r, w_ill, w_is_shift;
  logic signed [31:0] w_imm32;
  logic [6:0] w_opc, w_f7;
  logic [2:0] w_f3;

  assign w_opc = inst_data_i[6:0];
  assign w_f3  = inst_data_i[14:12];
  assign w_f7  = inst_data_i[31:25];

  // Flush cancels both handshakes in the cycle it is asserted.
  assign w_push = inst_valid_i & r_ready & ~flush_i;
  assign w_pop  = dec_valid_o & dec_ready_i & ~flush_i;

  // Classify the incoming instruction and detect illegal encodings.
  always_comb begin
    w_is_i = 1'b0; w_is_s = 1'b0; w_is_b = 1'b0;
    w_is_u = 1'b0; w_is_j = 1'b0; w_is_r = 1'b0;
    w_ill  = 1'b0; w_is_shift = 1'b0;
    case (w_opc)
      OPC_LUI, OPC_AUIPC: w_is_u = 1'b1;
      OPC_JAL:            w_is_j = 1'b1;
      OPC_JALR: begin
        w_is_i = 1'b1;
        w_ill  = (w_f3 != 3'b000);
      end
      OPC_BRANCH: begin
        w_is_b = 1'b1;
        w_ill  = (w_f3 == 3'b010) || (w_f3 == 3'b011);
      end
      OPC_LOAD: begin
        w_is_i = 1'b1;
        w_ill  = (w_f3 == 3'b011) || (w_f3 == 3'b110) || (w_f3 == 3'b111);
      end
      OPC_STORE: begin
        w_is_s = 1'b1;
        w_ill  = (w_f3 > 3'b010);
      end
      OPC_OPIMM: begin
        w_is_i     = 1'b1;
        w_is_shift = (w_f3 == 3'b001) || (w_f3 == 3'b101);
        w_ill      = w_is_shift && (w_f7 != 7'b0000000) && (w_f7 != 7'b0100000);
      end
      OPC_OP: begin
        w_is_r = 1'b1;
        case (w_f7)
          7'b0000000: w_ill = 1'b0;
          7'b0100000: w_ill = (w_f3 != 3'b000) && (w_f3 != 3'b101);
`ifdef MXRV_M_EXT_EN
          7'b0000001: w_ill = 1'b0;
`else
          7'b0000001: w_ill = 1'b1;
`endif
          default:    w_ill = 1'b1;
        endcase
      end
      default: w_ill = 1'b1;
    endcase
    if (inst_data_i[1:0] != 2'b11) w_ill = 1'b1;
  end

  // Assemble the decoded bundle, gating unused fields and enables to zero.
  always_comb begin
    w_imm32 = '0;
    if (w_is_i)      w_imm32 = {{20{inst_data_i[31]}}, inst_data_i[31:20]};
    else if (w_is_s) w_imm32 = {{20{inst_data_i[31]}}, inst_data_i[31:25], inst_data_i[11:7]};
    else if (w_is_b) w_imm32 = {{19{inst_data_i[31]}}, inst_data_i[31], inst_data_i[7],
                                inst_data_i[30:25], inst_data_i[11:8], 1'b0};
    else if (w_is_u) w_imm32 = {inst_data_i[31:12], 12'b0};
    else if (w_is_j) w_imm32 = {{11{inst_data_i[31]}}, inst_data_i[31], inst_data_i[19:12],
                                inst_data_i[20], inst_data_i[30:21], 1'b0};

    w_dec         = '0;
    w_dec.pc      = inst_addr_i;
    w_dec.opcode  = w_opc;
    w_dec.funct3  = w_f3;
    w_dec.funct7  = w_f7;
    w_dec.illegal = w_ill;
    if (!w_ill) begin
      w_dec.imm    = XLEN'(w_imm32);
      w_dec.rd     = (w_is_u | w_is_j | w_is_i | w_is_r) ? inst_data_i[11:7]  : 5'd0;
      w_dec.rs1    = (w_is_i | w_is_s | w_is_b | w_is_r) ? inst_data_i[19:15] : 5'd0;
      w_dec.rs2    = (w_is_s | w_is_b | w_is_r)          ? inst_data_i[24:20] : 5'd0;
      w_dec.shamt  = w_is_shift ? inst_data_i[24:20] : 5'd0;
      w_dec.rd_we  = (w_is_u | w_is_j | w_is_i | w_is_r) && (inst_data_i[11:7] != 5'd0);
      w_dec.rs1_en = w_is_i | w_is_s | w_is_b | w_is_r;
      w_dec.rs2_en = w_is_s | w_is_b | w_is_r;
    end
  end

  // Skid-buffer state and registered ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_EMPTY;
      r_ready <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_ready <= (w_state_nx != S_FULL);
    end
  end

  // Next-state logic; flush overrides every handshake.
  always_comb begin
    w_state_nx = r_state;
    if (flush_i) begin
      w_state_nx = S_EMPTY;
    end else begin
      case (r_state)
        S_EMPTY: if (w_push) w_state_nx = S_ONE;
        S_ONE: begin
          if (w_push && !w_pop)      w_state_nx = S_FULL;
          else if (!w_push && w_pop) w_state_nx = S_EMPTY;
        end
        S_FULL:  if (w_pop) w_state_nx = S_ONE;
        default: w_state_nx = S_EMPTY;
      endcase
    end
  end

  // Entry storage: new data lands behind the oldest entry, pops shift forward.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ent0 <= '0;
      r_ent1 <= '0;
    end else begin
      case (r_state)
        S_EMPTY: if (w_push) r_ent0 <= w_dec;
        S_ONE: begin
          if (w_push && w_pop) r_ent0 <= w_dec;
          else if (w_push)     r_ent1 <= w_dec;
        end
        S_FULL:  if (w_pop) r_ent0 <= r_ent1;
        default: ;
      endcase
    end
  end

  assign inst_ready_o = r_ready;
  assign dec_valid_o  = (r_state != S_EMPTY);
  assign dec_pc_o     = r_ent0.pc;
  assign opcode_o     = r_ent0.opcode;
  assign rd_o         = r_ent0.rd;
  assign rs1_o        = r_ent0.rs1;
  assign rs2_o        = r_ent0.rs2;
  assign shamt_o      = r_ent0.shamt;
  assign funct3_o     = r_ent0.funct3;
  assign funct7_o     = r_ent0.funct7;
  assign imm_o        = r_ent0.imm;
  assign rd_we_o      = r_ent0.rd_we;
  assign rs1_en_o     = r_ent0.rs1_en;
  assign rs2_en_o     = r_ent0.rs2_en;
  assign illegal_o    = r_ent0.illegal;

endmodule

// File: tb/tb_mxrv_id_stage.sv
// Directed self-checking bench for mxrv_id_stage (default 32-bit build).
module tb_mxrv_id_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush_i;
  logic        inst_valid_i;
  logic        inst_ready_o;
  logic [31:0] inst_data_i;
  logic [31:0] inst_addr_i;
  logic        dec_valid_o;
  logic        dec_ready_i;
  logic [31:0] dec_pc_o;
  logic [6:0]  opcode_o;
  logic [4:0]  rd_o, rs1_o, rs2_o, shamt_o;
  logic [2:0]  funct3_o;
  logic [6:0]  funct7_o;
  logic [31:0] imm_o;
  logic        rd_we_o, rs1_en_o, rs2_en_o, illegal_o;

  int total = 0;
  int bad   = 0;

  mxrv_id_stage #(.XLEN(32), .PC_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
    .inst_valid_i(inst_valid_i), .inst_ready_o(inst_ready_o),
    .inst_data_i(inst_data_i), .inst_addr_i(inst_addr_i),
    .dec_valid_o(dec_valid_o), .dec_ready_i(dec_ready_i),
    .dec_pc_o(dec_pc_o), .opcode_o(opcode_o), .rd_o(rd_o), .rs1_o(rs1_o),
    .rs2_o(rs2_o), .shamt_o(shamt_o), .funct3_o(funct3_o), .funct7_o(funct7_o),
    .imm_o(imm_o), .rd_we_o(rd_we_o), .rs1_en_o(rs1_en_o), .rs2_en_o(rs2_en_o),
    .illegal_o(illegal_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush_i = 1'b0; inst_valid_i = 1'b0; dec_ready_i = 1'b1;
    inst_data_i = 32'h0; inst_addr_i = 32'h0;
    #2;
    total++; if (inst_ready_o !== 1'b0) begin bad++; $display("FAIL rst_ready: got %b want 0", inst_ready_o); end
    total++; if (dec_valid_o !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", dec_valid_o); end
    tick(); tick();
    total++; if (imm_o !== 32'h0 || dec_pc_o !== 32'h0 || rd_we_o !== 1'b0) begin
      bad++; $display("FAIL rst_bundle: imm=%h pc=%h we=%b want zeros", imm_o, dec_pc_o, rd_we_o); end
    total++; if (inst_ready_o !== 1'b0) begin bad++; $display("FAIL rst_hold_ready: got %b want 0", inst_ready_o); end
    rst_n = 1'b1;
    tick();
    total++; if (inst_ready_o !== 1'b1) begin bad++; $display("FAIL rst_release_ready: got %b want 1", inst_ready_o); end
    total++; if (dec_valid_o !== 1'b0) begin bad++; $display("FAIL rst_release_valid: got %b want 0", dec_valid_o); end
  endtask

  task automatic test_addi();
    dec_ready_i = 1'b1;
    inst_valid_i = 1'b1; inst_data_i = 32'hFFF10093; inst_addr_i = 32'h100;
    tick();
    inst_valid_i = 1'b0;
    total++; if (dec_valid_o !== 1'b1) begin bad++; $display("FAIL addi_valid: got %b want 1", dec_valid_o); end
    total++; if (rd_o !== 5'd1 || rs1_o !== 5'd2 || rs2_o !== 5'd0) begin
      bad++; $display("FAIL addi_regs: rd=%0d rs1=%0d rs2=%0d want 1 2 0", rd_o, rs1_o, rs2_o); end
    total++; if (imm_o !== 32'hFFFFFFFF) begin bad++; $display("FAIL addi_imm: got %h want ffffffff", imm_o); end
    total++; if ({rd_we_o, rs1_en_o, rs2_en_o, illegal_o} !== 4'b1100) begin
      bad++; $display("FAIL addi_ctl: got %b want 1100", {rd_we_o, rs1_en_o, rs2_en_o, illegal_o}); end
    total++; if (dec_pc_o !== 32'h100) begin bad++; $display("FAIL addi_pc: got %h want 100", dec_pc_o); end
    tick();
    total++; if (dec_valid_o !== 1'b0) begin bad++; $display("FAIL addi_drain: got %b want 0", dec_valid_o); end
  endtask

  task automatic test_lui_beq();
    dec_ready_i = 1'b1;
    inst_valid_i = 1'b1; inst_data_i = 32'h123452B7; inst_addr_i = 32'h110;
    tick();
    inst_data_i = 32'hFE000EE3; inst_addr_i = 32'h114;
    total++; if (imm_o !== 32'h12345000 || rd_o !== 5'd5 || rd_we_o !== 1'b1 || rs1_en_o !== 1'b0) begin
      bad++; $display("FAIL lui: imm=%h rd=%0d we=%b rs1en=%b want 12345000 5 1 0", imm_o, rd_o, rd_we_o, rs1_en_o); end
    tick();
    inst_valid_i = 1'b0;
    total++; if (imm_o !== 32'hFFFFFFFC || rd_we_o !== 1'b0 || rs2_en_o !== 1'b1 || rs1_en_o !== 1'b1) begin
      bad++; $display("FAIL beq: imm=%h we=%b rs1en=%b rs2en=%b want fffffffc 0 1 1", imm_o, rd_we_o, rs1_en_o, rs2_en_o); end
    total++; if (dec_pc_o !== 32'h114 || rd_o !== 5'd0) begin
      bad++; $display("FAIL beq_pc: pc=%h rd=%0d want 114 0", dec_pc_o, rd_o); end
    tick();
    total++; if (dec_valid_o !== 1'b0) begin bad++; $display("FAIL lui_beq_drain: got %b want 0", dec_valid_o); end
  endtask

  task automatic test_decode();
    // inst, imm, rd, rs1, rs2, shamt, {we,rs1en,rs2en,ill}
    logic [31:0] v_inst [8] = '{32'h40208033, 32'h0020A423, 32'h001000EF, 32'h00000000,
                                32'h00013083, 32'h40315093, 32'h04315093, 32'h0000A063};
    logic [31:0] v_imm  [8] = '{32'h0, 32'h8, 32'h800, 32'h0, 32'h0, 32'h403, 32'h0, 32'h0};
    logic [4:0]  v_rd   [8] = '{5'd0, 5'd0, 5'd1, 5'd0, 5'd0, 5'd1, 5'd0, 5'd0};
    logic [4:0]  v_rs1  [8] = '{5'd1, 5'd1, 5'd0, 5'd0, 5'd0, 5'd2, 5'd0, 5'd0};
    logic [4:0]  v_rs2  [8] = '{5'd2, 5'd2, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0};
    logic [4:0]  v_sh   [8] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd3, 5'd0, 5'd0};
    logic [3:0]  v_ctl  [8] = '{4'b0110, 4'b0110, 4'b1000, 4'b0001,
                                4'b0001, 4'b1100, 4'b0001, 4'b0001};
    dec_ready_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      inst_valid_i = 1'b1; inst_data_i = v_inst[i]; inst_addr_i = 32'h200 + 32'(i * 4);
      tick();
      inst_valid_i = 1'b0;
      total++; if (imm_o !== v_imm[i] || rd_o !== v_rd[i] || rs1_o !== v_rs1[i] || rs2_o !== v_rs2[i] || shamt_o !== v_sh[i]) begin
        bad++; $display("FAIL dec%0d_fields: imm=%h rd=%0d rs1=%0d rs2=%0d sh=%0d want %h %0d %0d %0d %0d",
                        i, imm_o, rd_o, rs1_o, rs2_o, shamt_o, v_imm[i], v_rd[i], v_rs1[i], v_rs2[i], v_sh[i]); end
      total++; if ({rd_we_o, rs1_en_o, rs2_en_o, illegal_o} !== v_ctl[i] || dec_pc_o !== 32'h200 + 32'(i * 4)) begin
        bad++; $display("FAIL dec%0d_ctl: ctl=%b pc=%h want %b %h", i, {rd_we_o, rs1_en_o, rs2_en_o, illegal_o},
                        dec_pc_o, v_ctl[i], 32'h200 + 32'(i * 4)); end
      tick();
    end
  endtask

  task automatic test_mul();
    logic exp_ill;
`ifdef MXRV_M_EXT_EN
    exp_ill = 1'b0;
`else
    exp_ill = 1'b1;
`endif
    dec_ready_i = 1'b1;
    inst_valid_i = 1'b1; inst_data_i = 32'h022081B3; inst_addr_i = 32'h280;
    tick();
    inst_valid_i = 1'b0;
    total++; if (illegal_o !== exp_ill) begin bad++; $display("FAIL mul_illegal: got %b want %b", illegal_o, exp_ill); end
    total++; if (rd_we_o !== ~exp_ill || rs1_en_o !== ~exp_ill || rs2_en_o !== ~exp_ill) begin
      bad++; $display("FAIL mul_en: we=%b rs1en=%b rs2en=%b want all %b", rd_we_o, rs1_en_o, rs2_en_o, ~exp_ill); end
    total++; if (imm_o !== 32'h0) begin bad++; $display("FAIL mul_imm: got %h want 0", imm_o); end
    tick();
  endtask

  task automatic test_back_to_back();
    dec_ready_i = 1'b0;
    inst_valid_i = 1'b1; inst_data_i = 32'h00100093; inst_addr_i = 32'h300;
    tick();
    total++; if (inst_ready_o !== 1'b1 || dec_pc_o !== 32'h300) begin
      bad++; $display("FAIL b2b_one: ready=%b pc=%h want 1 300", inst_ready_o, dec_pc_o); end
    inst_data_i = 32'h00200093; inst_addr_i = 32'h304;
    tick();
    total++; if (inst_ready_o !== 1'b0 || dec_valid_o !== 1'b1) begin
      bad++; $display("FAIL b2b_full: ready=%b valid=%b want 0 1", inst_ready_o, dec_valid_o); end
    inst_data_i = 32'h00300093; inst_addr_i = 32'h308;
    tick();
    total++; if (dec_pc_o !== 32'h300 || imm_o !== 32'h1 || inst_ready_o !== 1'b0) begin
      bad++; $display("FAIL b2b_hold: pc=%h imm=%h ready=%b want 300 1 0", dec_pc_o, imm_o, inst_ready_o); end
    dec_ready_i = 1'b1;
    tick();
    total++; if (dec_pc_o !== 32'h304 || imm_o !== 32'h2 || inst_ready_o !== 1'b1) begin
      bad++; $display("FAIL b2b_second: pc=%h imm=%h ready=%b want 304 2 1", dec_pc_o, imm_o, inst_ready_o); end
    tick();
    inst_valid_i = 1'b0;
    total++; if (dec_pc_o !== 32'h308 || imm_o !== 32'h3 || dec_valid_o !== 1'b1) begin
      bad++; $display("FAIL b2b_third: pc=%h imm=%h valid=%b want 308 3 1", dec_pc_o, imm_o, dec_valid_o); end
    tick();
    total++; if (dec_valid_o !== 1'b0) begin bad++; $display("FAIL b2b_drain: got %b want 0", dec_valid_o); end
  endtask

  task automatic test_flush();
    dec_ready_i = 1'b0;
    inst_valid_i = 1'b1; inst_data_i = 32'h00100093; inst_addr_i = 32'h400;
    tick();
    inst_addr_i = 32'h404;
    tick();
    total++; if (inst_ready_o !== 1'b0) begin bad++; $display("FAIL flush_prefull: ready=%b want 0", inst_ready_o); end
    inst_addr_i = 32'h40C; flush_i = 1'b1;
    tick();
    total++; if (dec_valid_o !== 1'b0 || inst_ready_o !== 1'b1) begin
      bad++; $display("FAIL flush_full: valid=%b ready=%b want 0 1", dec_valid_o, inst_ready_o); end
    flush_i = 1'b0; inst_valid_i = 1'b0;
    tick();
    total++; if (dec_valid_o !== 1'b0) begin bad++; $display("FAIL flush_full_after: valid=%b want 0", dec_valid_o); end
    inst_valid_i = 1'b1; inst_addr_i = 32'h410;
    tick();
    inst_addr_i = 32'h414; flush_i = 1'b1; dec_ready_i = 1'b1;
    tick();
    flush_i = 1'b0; inst_valid_i = 1'b0;
    total++; if (dec_valid_o !== 1'b0) begin bad++; $display("FAIL flush_one: valid=%b want 0", dec_valid_o); end
    tick();
    total++; if (dec_valid_o !== 1'b0 || inst_ready_o !== 1'b1) begin
      bad++; $display("FAIL flush_discard: valid=%b ready=%b want 0 1", dec_valid_o, inst_ready_o); end
  endtask

  task automatic test_reset_mid();
    dec_ready_i = 1'b0;
    inst_valid_i = 1'b1; inst_data_i = 32'hFFF10093; inst_addr_i = 32'h500;
    tick();
    inst_valid_i = 1'b0;
    total++; if (dec_valid_o !== 1'b1) begin bad++; $display("FAIL rmid_pre: valid=%b want 1", dec_valid_o); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (dec_valid_o !== 1'b0 || inst_ready_o !== 1'b0 || dec_pc_o !== 32'h0 || imm_o !== 32'h0) begin
      bad++; $display("FAIL rmid_async: valid=%b ready=%b pc=%h imm=%h want 0 0 0 0", dec_valid_o, inst_ready_o, dec_pc_o, imm_o); end
    tick();
    rst_n = 1'b1; dec_ready_i = 1'b1;
    tick();
    total++; if (inst_ready_o !== 1'b1 || dec_valid_o !== 1'b0) begin
      bad++; $display("FAIL rmid_release: ready=%b valid=%b want 1 0", inst_ready_o, dec_valid_o); end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_lui_beq();
    test_decode();
    test_mul();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
